axi_reg_slave: RTL and testbench

AXI_REG_SLAVE -- requirements
Module: axi_reg_slave

---
 rtl/axi_reg_slave_if.sv | 79 +++++++
 rtl/axi_reg_slave.sv | 238 +++++++++++++++++++++++
 tb/tb_axi_reg_slave.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_reg_slave_if.sv
// Bus bundle for axi_reg_slave: AW, W, B, AR and R channels of an
// AXI3-style slave port. Clock and reset stay outside the bundle.
interface axi_reg_slave_if #(
    parameter int AXI_WIDTH_CID = 4,
    parameter int AXI_WIDTH_ID  = 4,
    parameter int AXI_WIDTH_AD  = 32,
    parameter int AXI_WIDTH_DA  = 32
);
    localparam int AXI_WIDTH_SID = AXI_WIDTH_CID + AXI_WIDTH_ID;
    localparam int AXI_WIDTH_DS  = AXI_WIDTH_DA / 8;

    // Write address channel
    logic [AXI_WIDTH_SID-1:0] AWID;
    logic [AXI_WIDTH_AD-1:0]  AWADDR;
    logic [3:0]               AWLEN;
    logic [1:0]               AWLOCK;
    logic [2:0]               AWSIZE;
    logic [1:0]               AWBURST;
    logic                     AWVALID;
    logic                     AWREADY;

    // Write data channel
    logic [AXI_WIDTH_SID-1:0] WID;
    logic [AXI_WIDTH_DA-1:0]  WDATA;
    logic [AXI_WIDTH_DS-1:0]  WSTRB;
    logic                     WLAST;
    logic                     WVALID;
    logic                     WREADY;

    // Write response channel
    logic [AXI_WIDTH_SID-1:0] BID;
    logic [1:0]               BRESP;
    logic                     BVALID;
    logic                     BREADY;

    // Read address channel
    logic [AXI_WIDTH_SID-1:0] ARID;
    logic [AXI_WIDTH_AD-1:0]  ARADDR;
    logic [3:0]               ARLEN;
    logic [1:0]               ARLOCK;
    logic [2:0]               ARSIZE;
    logic [1:0]               ARBURST;
    logic                     ARVALID;
    logic                     ARREADY;

    // Read data channel
    logic [AXI_WIDTH_SID-1:0] RID;
    logic [AXI_WIDTH_DA-1:0]  RDATA;
    logic [1:0]               RRESP;
    logic                     RLAST;
    logic                     RVALID;
    logic                     RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWLOCK, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WID, WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARLOCK, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWLOCK, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WID, WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARLOCK, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axi_reg_slave.sv
// AXI slave exposing sixteen 32-bit registers in a 64-byte window.
// Registers 0-14 are read/write with byte strobes; register 15 is a
// read-only identification word. Independent write and read FSMs, one
// beat per cycle each, with DECERR for out-of-window and SLVERR for
// unsupported transfer size or WLAST misplacement.
module axi_reg_slave #(
    parameter int                      AXI_WIDTH_CID = 4,
    parameter int                      AXI_WIDTH_ID  = 4,
    parameter int                      AXI_WIDTH_AD  = 32,
    parameter int                      AXI_WIDTH_DA  = 32,
    parameter logic [AXI_WIDTH_AD-1:0] P_ADDR_BASE   = 32'h0000_0000,
    parameter logic [31:0]             P_ID_VALUE    = 32'hA5A5_0001
) (
    input  logic           ACLK,
    input  logic           ARESETn,
    axi_reg_slave_if.slave axi
);
    localparam int AXI_WIDTH_SID = AXI_WIDTH_CID + AXI_WIDTH_ID;
    localparam int AXI_WIDTH_DS  = AXI_WIDTH_DA / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [2:0] SIZE_WORD   = 3'b010;
    localparam logic [3:0] ID_REG      = 4'd15;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    // Out-of-window wins over a bad size; only word transfers are served.
    function automatic logic [1:0] access_status(input logic [AXI_WIDTH_AD-7:0] win,
                                                 input logic [2:0]              size);
        if (win != P_ADDR_BASE[AXI_WIDTH_AD-1:6]) return RESP_DECERR;
        if (size != SIZE_WORD)                    return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    // FIXED holds the register index; INCR and WRAP step it, wrapping at 16.
    function automatic logic [3:0] next_index(input logic [3:0] idx, input logic [1:0] burst);
        return (burst == BURST_FIXED) ? idx : idx + 4'd1;
    endfunction

    // Ready outputs stay low until the first edge after reset release.
    logic ready_en_q;

    // Write side
    w_state_e                 w_state_q, w_state_d;
    logic [AXI_WIDTH_SID-1:0] w_id_q;
    logic [3:0]               w_idx_q, w_len_q, w_cnt_q;
    logic [1:0]               w_burst_q, w_status_q;
    logic                     w_lerr_q;
    logic [AXI_WIDTH_SID-1:0] bid_q;
    logic [1:0]               bresp_q;
    logic                     awready, wready, bvalid;
    logic                     aw_hs, w_hs, w_last_beat, wlast_err;

    // Read side
    r_state_e                 r_state_q, r_state_d;
    logic [AXI_WIDTH_SID-1:0] rid_q;
    logic [3:0]               r_idx_q, r_len_q, r_cnt_q, r_next_idx, rd_idx;
    logic [1:0]               r_burst_q, rresp_q, ar_status;
    logic [AXI_WIDTH_DA-1:0]  rdata_q, rd_word;
    logic                     rlast_q;
    logic                     arready, rvalid;
    logic                     ar_hs, r_hs, r_last_beat;

    // Register file; entry 15 is never written and is shadowed by the ID word.
    logic [AXI_WIDTH_DA-1:0]  regs_q [16];

    assign aw_hs       = axi.AWVALID && awready;
    assign w_hs        = axi.WVALID && wready;
    assign w_last_beat = (w_cnt_q == w_len_q);
    assign wlast_err   = (axi.WLAST != w_last_beat);

    assign ar_hs       = axi.ARVALID && arready;
    assign r_hs        = rvalid && axi.RREADY;
    assign r_last_beat = (r_cnt_q == r_len_q);
    assign ar_status   = access_status(axi.ARADDR[AXI_WIDTH_AD-1:6], axi.ARSIZE);
    assign r_next_idx  = next_index(r_idx_q, r_burst_q);
    assign rd_idx      = ar_hs ? axi.ARADDR[5:2] : r_next_idx;
    assign rd_word     = (rd_idx == ID_REG) ? P_ID_VALUE : regs_q[rd_idx];

    assign axi.AWREADY = awready;
    assign axi.WREADY  = wready;
    assign axi.BVALID  = bvalid;
    assign axi.BID     = bid_q;
    assign axi.BRESP   = bresp_q;
    assign axi.ARREADY = arready;
    assign axi.RVALID  = rvalid;
    assign axi.RID     = rid_q;
    assign axi.RDATA   = rdata_q;
    assign axi.RRESP   = rresp_q;
    assign axi.RLAST   = rlast_q;

    // Arm the address-ready outputs one edge after reset is released.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) ready_en_q <= 1'b0;
        else          ready_en_q <= 1'b1;
    end

    // Write FSM state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) w_state_q <= W_IDLE;
        else          w_state_q <= w_state_d;
    end

    // Write FSM next state and channel handshake outputs.
    // NOTE: every output gets a default before the case so no path leaves it unassigned and infers a latch.
    always_comb begin
        w_state_d = w_state_q;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                awready = ready_en_q;
                if (axi.AWVALID && ready_en_q) w_state_d = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (axi.WVALID && w_last_beat) w_state_d = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (axi.BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write burst context, beat counting and the registered B response.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_id_q     <= '0;
            w_idx_q    <= '0;
            w_len_q    <= '0;
            w_cnt_q    <= '0;
            w_burst_q  <= '0;
            w_status_q <= RESP_OKAY;
            w_lerr_q   <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                w_id_q     <= axi.AWID;
                w_idx_q    <= axi.AWADDR[5:2];
                w_len_q    <= axi.AWLEN;
                w_burst_q  <= axi.AWBURST;
                w_cnt_q    <= '0;
                w_status_q <= access_status(axi.AWADDR[AXI_WIDTH_AD-1:6], axi.AWSIZE);
                w_lerr_q   <= 1'b0;
            end
            if (w_hs) begin
                w_cnt_q <= w_cnt_q + 4'd1;
                w_idx_q <= next_index(w_idx_q, w_burst_q);
                if (wlast_err) w_lerr_q <= 1'b1;
                if (w_last_beat) begin
                    bid_q <= w_id_q;
                    if (w_status_q != RESP_OKAY)   bresp_q <= w_status_q;
                    else if (w_lerr_q || wlast_err) bresp_q <= RESP_SLVERR;
                    else                            bresp_q <= RESP_OKAY;
                end
            end
        end
    end

    // Byte-strobed register update on each accepted, error-free write beat.
    // NOTE: the register file is reset because registers must read zero after reset; plain RAM storage would not be reset.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else if (w_hs && (w_status_q == RESP_OKAY) && (w_idx_q != ID_REG)) begin
            for (int b = 0; b < AXI_WIDTH_DS; b++) begin
                if (axi.WSTRB[b]) regs_q[w_idx_q][8*b +: 8] <= axi.WDATA[8*b +: 8];
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_state_q <= R_IDLE;
        else          r_state_q <= r_state_d;
    end

    // Read FSM next state and channel handshake outputs.
    always_comb begin
        r_state_d = r_state_q;
        arready   = 1'b0;
        rvalid    = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                arready = ready_en_q;
                if (axi.ARVALID && ready_en_q) r_state_d = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (axi.RREADY && r_last_beat) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read data path: beat 0 is captured at the AR handshake, later beats at
    // each R handshake. Values are only reloaded on those edges, so they hold
    // while the master stalls, and a same-edge write is not yet visible.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rid_q     <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_burst_q <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
        end else if (ar_hs) begin
            rid_q     <= axi.ARID;
            r_idx_q   <= axi.ARADDR[5:2];
            r_len_q   <= axi.ARLEN;
            r_burst_q <= axi.ARBURST;
            r_cnt_q   <= '0;
            rresp_q   <= ar_status;
            rdata_q   <= (ar_status == RESP_OKAY) ? rd_word : '0;
            rlast_q   <= (axi.ARLEN == 4'd0);
        end else if (r_hs) begin
            if (r_last_beat) begin
                rlast_q <= 1'b0;
            end else begin
                r_idx_q <= r_next_idx;
                r_cnt_q <= r_cnt_q + 4'd1;
                rdata_q <= (rresp_q == RESP_OKAY) ? rd_word : '0;
                rlast_q <= ((r_cnt_q + 4'd1) == r_len_q);
            end
        end
    end
endmodule

// File: tb/tb_axi_reg_slave.sv
// Randomized self-checking bench for axi_reg_slave against a register-array
// reference model built from the register-map rules.
module tb_axi_reg_slave;
    localparam logic [31:0] ID_VALUE = 32'hA5A5_0001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_reg_slave_if bus ();
    axi_reg_slave dut (.ACLK(clk), .ARESETn(rst_n), .axi(bus));

    int vectors = 0;
    int miscompares = 0;

    // Reference model and transaction buffers
    logic [31:0] model_regs [16];
    logic [31:0] wr_data [16];
    logic [3:0]  wr_strb [16];
    logic [1:0]  wr_bresp;
    logic [7:0]  wr_bid;
    int          wr_blat;
    logic [31:0] rd_data [$];
    logic [1:0]  rd_resp [$];
    logic        rd_last [$];
    logic [7:0]  rd_id [$];
    int          rd_stall_bad;
    int          rd_lat;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    function automatic logic [1:0] model_status(input logic [31:0] addr, input logic [2:0] size);
        if (addr[31:6] != 26'h0) return 2'b11;
        if (size != 3'd2)        return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_read(input int idx);
        return (idx == 15) ? ID_VALUE : model_regs[idx];
    endfunction

    // Expected data of beat 'beat' of a read burst.
    function automatic logic [31:0] model_beat(input logic [31:0] addr, input logic [2:0] size,
                                               input logic [1:0] burst, input int beat);
        int idx;
        if (model_status(addr, size) != 2'b00) return 32'h0;
        idx = (int'(addr[5:2]) + ((burst == 2'b00) ? 0 : beat)) % 16;
        return model_read(idx);
    endfunction

    // Applies wr_data/wr_strb to the model and returns the expected BRESP.
    function automatic logic [1:0] model_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                                               input logic [1:0] burst, input int bad_beat);
        logic [1:0] st;
        int idx;
        st = model_status(addr, size);
        if (st != 2'b00) return st;
        idx = int'(addr[5:2]);
        for (int i = 0; i <= len; i++) begin
            if (idx != 15)
                for (int b = 0; b < 4; b++)
                    if (wr_strb[i][b]) model_regs[idx][8*b +: 8] = wr_data[i][8*b +: 8];
            if (burst != 2'b00) idx = (idx + 1) % 16;
        end
        return (bad_beat >= 0) ? 2'b10 : 2'b00;
    endfunction

    task automatic init_bus();
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWLOCK = '0; bus.AWSIZE = '0;
        bus.AWBURST = '0; bus.AWVALID = 1'b0;
        bus.WID = '0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b0;
        bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARLOCK = '0; bus.ARSIZE = '0;
        bus.ARBURST = '0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;
    endtask

    // Full write burst; bad_beat >= 0 flips WLAST on that beat.
    task automatic axi_write(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [7:0] id, input int bad_beat);
        int n;
        @(posedge clk); #1;
        bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size;
        bus.AWBURST = burst; bus.AWLOCK = 2'($urandom); bus.AWVALID = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.AWREADY && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin vectors++; miscompares++; $display("FAIL aw_timeout: AWREADY got 0 want 1"); end
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.WID = 8'($urandom); bus.WDATA = wr_data[i]; bus.WSTRB = wr_strb[i];
            bus.WLAST = (i == int'(len)) ^ (i == bad_beat); bus.WVALID = 1'b1;
            n = 0;
            @(negedge clk);
            while (!bus.WREADY && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) begin vectors++; miscompares++; $display("FAIL w_timeout: WREADY got 0 want 1"); end
            @(posedge clk); #1;
        end
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.BVALID && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin vectors++; miscompares++; $display("FAIL b_timeout: BVALID got 0 want 1"); end
        wr_blat = n;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        wr_bresp = bus.BRESP; wr_bid = bus.BID;
        bus.BREADY = 1'b1;
        @(posedge clk); #1;
        bus.BREADY = 1'b0;
    endtask

    // Full read burst; toggle makes RREADY alternate every cycle starting low.
    task automatic axi_read(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [7:0] id, input bit toggle);
        int n, beats;
        logic have_snap;
        logic [42:0] snap;
        rd_data.delete(); rd_resp.delete(); rd_last.delete(); rd_id.delete();
        rd_stall_bad = 0; rd_lat = -1; have_snap = 1'b0; snap = '0;
        @(posedge clk); #1;
        bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = size;
        bus.ARBURST = burst; bus.ARLOCK = 2'($urandom); bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.ARREADY && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin vectors++; miscompares++; $display("FAIL ar_timeout: ARREADY got 0 want 1"); end
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
        bus.RREADY = !toggle;
        beats = 0; n = 0;
        while (beats <= int'(len) && n < 200) begin
            @(negedge clk);
            if (bus.RVALID) begin
                if (rd_lat < 0) rd_lat = n;
                if (have_snap && {bus.RDATA, bus.RRESP, bus.RLAST, bus.RID} !== snap) rd_stall_bad++;
                if (bus.RREADY) begin
                    rd_data.push_back(bus.RDATA); rd_resp.push_back(bus.RRESP);
                    rd_last.push_back(bus.RLAST); rd_id.push_back(bus.RID);
                    beats++; have_snap = 1'b0;
                end else begin
                    snap = {bus.RDATA, bus.RRESP, bus.RLAST, bus.RID}; have_snap = 1'b1;
                end
            end
            n++;
            @(posedge clk); #1;
            if (toggle) bus.RREADY = !bus.RREADY;
        end
        bus.RREADY = 1'b0;
        if (beats <= int'(len)) begin vectors++; miscompares++; $display("FAIL r_timeout: beats got %0d want %0d", beats, len + 1); end
    endtask

    task automatic test_reset();
        logic [7:0] id;
        init_bus();
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) model_regs[i] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID, bus.RLAST} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 000000", {bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID, bus.RLAST});
        end
        vectors++;
        if ({bus.BID, bus.BRESP, bus.RID, bus.RRESP, bus.RDATA} !== 52'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 0", {bus.BID, bus.BRESP, bus.RID, bus.RRESP, bus.RDATA});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({bus.AWREADY, bus.ARREADY} !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b want 11", {bus.AWREADY, bus.ARREADY});
        end
        id = 8'($urandom);
        axi_read(32'h0, 4'd15, 3'd2, 2'b01, id, 1'b0);
        for (int i = 0; i < rd_data.size(); i++) begin
            vectors++;
            if (rd_data[i] !== model_beat(32'h0, 3'd2, 2'b01, i)) begin
                miscompares++;
                $display("FAIL reset_regs[%0d]: got %h want %h", i, rd_data[i], model_beat(32'h0, 3'd2, 2'b01, i));
            end
        end
    endtask

    task automatic test_single_write_read();
        logic [7:0] id;
        logic [1:0] exp;
        id = 8'($urandom);
        wr_data[0] = 32'h1234_5678; wr_strb[0] = 4'hF;
        exp = model_write(32'h8, 0, 3'd2, 2'b01, -1);
        axi_write(32'h8, 4'd0, 3'd2, 2'b01, id, -1);
        vectors++;
        if (wr_bresp !== 2'b00 || wr_bresp !== exp) begin miscompares++; $display("FAIL single_bresp: got %b want 00", wr_bresp); end
        vectors++;
        if (wr_bid !== id) begin miscompares++; $display("FAIL single_bid: got %h want %h", wr_bid, id); end
        vectors++;
        if (wr_blat !== 0) begin miscompares++; $display("FAIL single_b_latency: got %0d want 0", wr_blat); end
        axi_read(32'h8, 4'd0, 3'd2, 2'b01, id, 1'b0);
        vectors++;
        if (rd_data.size() != 1 || rd_data[0] !== 32'h1234_5678 || rd_last[0] !== 1'b1 || rd_resp[0] !== 2'b00) begin
            miscompares++;
            $display("FAIL single_read: got n=%0d data=%h last=%b resp=%b want 12345678 1 00", rd_data.size(), rd_data[0], rd_last[0], rd_resp[0]);
        end
        vectors++;
        if (rd_lat !== 0 || rd_id[0] !== id) begin
            miscompares++;
            $display("FAIL single_r_latency_id: got lat=%0d id=%h want 0 %h", rd_lat, rd_id[0], id);
        end
    endtask

    task automatic test_incr_wrap();
        logic [7:0] id;
        logic [1:0] exp;
        id = 8'($urandom);
        for (int i = 0; i < 4; i++) begin wr_data[i] = 32'(i + 1); wr_strb[i] = 4'hF; end
        exp = model_write(32'h38, 3, 3'd2, 2'b01, -1);
        axi_write(32'h38, 4'd3, 3'd2, 2'b01, id, -1);
        vectors++;
        if (wr_bresp !== exp) begin miscompares++; $display("FAIL wrap_bresp: got %b want %b", wr_bresp, exp); end
        axi_read(32'h38, 4'd3, 3'd2, 2'b10, id, 1'b0);
        vectors++;
        if (rd_data.size() != 4) begin miscompares++; $display("FAIL wrap_beats: got %0d want 4", rd_data.size()); end
        for (int i = 0; i < rd_data.size(); i++) begin
            vectors++;
            if (rd_data[i] !== model_beat(32'h38, 3'd2, 2'b10, i) || rd_last[i] !== (i == 3)) begin
                miscompares++;
                $display("FAIL wrap_beat[%0d]: got %h/%b want %h/%b", i, rd_data[i], rd_last[i], model_beat(32'h38, 3'd2, 2'b10, i), i == 3);
            end
        end
        axi_read(32'h3C, 4'd0, 3'd2, 2'b01, id, 1'b0);
        vectors++;
        if (rd_data[0] !== 32'hA5A5_0001) begin miscompares++; $display("FAIL id_reg: got %h want a5a50001", rd_data[0]); end
        axi_read(32'h0, 4'd1, 3'd2, 2'b01, id, 1'b0);
        vectors++;
        if (rd_data[0] !== 32'd3 || rd_data[1] !== 32'd4) begin
            miscompares++;
            $display("FAIL wrap_reg0_1: got %h %h want 3 4", rd_data[0], rd_data[1]);
        end
    endtask

    task automatic test_errors();
        logic [1:0] exp;
        wr_data[0] = 32'($urandom); wr_strb[0] = 4'hF;
        exp = model_write(32'h40, 0, 3'd2, 2'b01, -1);
        axi_write(32'h40, 4'd0, 3'd2, 2'b01, 8'h11, -1);
        vectors++;
        if (wr_bresp !== 2'b11) begin miscompares++; $display("FAIL decerr_bresp: got %b want 11", wr_bresp); end
        exp = model_write(32'h10, 0, 3'd1, 2'b01, -1);
        axi_write(32'h10, 4'd0, 3'd1, 2'b01, 8'h22, -1);
        vectors++;
        if (wr_bresp !== 2'b10) begin miscompares++; $display("FAIL slverr_bresp: got %b want 10", wr_bresp); end
        exp = model_write(32'h80, 0, 3'd1, 2'b01, -1);
        axi_write(32'h80, 4'd0, 3'd1, 2'b01, 8'h33, -1);
        vectors++;
        if (wr_bresp !== 2'b11 || wr_bresp !== exp) begin miscompares++; $display("FAIL precedence_bresp: got %b want 11", wr_bresp); end
        axi_read(32'h40, 4'd0, 3'd2, 2'b01, 8'h44, 1'b0);
        vectors++;
        if (rd_data[0] !== 32'h0 || rd_resp[0] !== 2'b11 || rd_last[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL decerr_read: got %h/%b/%b want 0/11/1", rd_data[0], rd_resp[0], rd_last[0]);
        end
        axi_read(32'h10, 4'd0, 3'd1, 2'b01, 8'h55, 1'b0);
        vectors++;
        if (rd_data[0] !== 32'h0 || rd_resp[0] !== 2'b10) begin
            miscompares++;
            $display("FAIL slverr_read: got %h/%b want 0/10", rd_data[0], rd_resp[0]);
        end
        axi_read(32'h0, 4'd15, 3'd2, 2'b01, 8'h66, 1'b0);
        for (int i = 0; i < rd_data.size(); i++) begin
            vectors++;
            if (rd_data[i] !== model_beat(32'h0, 3'd2, 2'b01, i)) begin
                miscompares++;
                $display("FAIL err_no_change[%0d]: got %h want %h", i, rd_data[i], model_beat(32'h0, 3'd2, 2'b01, i));
            end
        end
    endtask

    task automatic test_strobe();
        logic [1:0] exp;
        wr_data[0] = 32'hFFFF_FFFF; wr_strb[0] = 4'hF;
        exp = model_write(32'h8, 0, 3'd2, 2'b01, -1);
        axi_write(32'h8, 4'd0, 3'd2, 2'b01, 8'h01, -1);
        wr_data[0] = 32'h0; wr_strb[0] = 4'b0101;
        exp = model_write(32'h8, 0, 3'd2, 2'b01, -1);
        axi_write(32'h8, 4'd0, 3'd2, 2'b01, 8'h02, -1);
        vectors++;
        if (wr_bresp !== exp) begin miscompares++; $display("FAIL strobe_bresp: got %b want %b", wr_bresp, exp); end
        axi_read(32'h8, 4'd0, 3'd2, 2'b01, 8'h03, 1'b0);
        vectors++;
        if (rd_data[0] !== 32'hFF00_FF00) begin miscompares++; $display("FAIL strobe_read: got %h want ff00ff00", rd_data[0]); end
    endtask

    task automatic test_fixed_and_wlast();
        logic [1:0] exp;
        for (int i = 0; i < 4; i++) begin wr_data[i] = 32'($urandom); wr_strb[i] = 4'($urandom); end
        exp = model_write(32'h14, 3, 3'd2, 2'b00, -1);
        axi_write(32'h14, 4'd3, 3'd2, 2'b00, 8'h10, -1);
        axi_read(32'h14, 4'd2, 3'd2, 2'b00, 8'h20, 1'b0);
        for (int i = 0; i < rd_data.size(); i++) begin
            vectors++;
            if (rd_data[i] !== model_beat(32'h14, 3'd2, 2'b00, i)) begin
                miscompares++;
                $display("FAIL fixed_beat[%0d]: got %h want %h", i, rd_data[i], model_beat(32'h14, 3'd2, 2'b00, i));
            end
        end
        wr_data[0] = 32'($urandom); wr_strb[0] = 4'hF;
        exp = model_write(32'h18, 0, 3'd2, 2'b01, 0);
        axi_write(32'h18, 4'd0, 3'd2, 2'b01, 8'h30, 0);
        vectors++;
        if (wr_bresp !== 2'b10 || wr_bresp !== exp) begin miscompares++; $display("FAIL wlast_missing: got %b want 10", wr_bresp); end
        for (int i = 0; i < 3; i++) begin wr_data[i] = 32'($urandom); wr_strb[i] = 4'hF; end
        exp = model_write(32'h20, 2, 3'd2, 2'b01, 0);
        axi_write(32'h20, 4'd2, 3'd2, 2'b01, 8'h40, 0);
        vectors++;
        if (wr_bresp !== 2'b10) begin miscompares++; $display("FAIL wlast_early: got %b want 10", wr_bresp); end
    endtask

    task automatic test_read_stall();
        logic [31:0] addr;
        logic [7:0] id;
        logic [1:0] exp;
        for (int i = 0; i < 15; i++) begin wr_data[i] = 32'($urandom); wr_strb[i] = 4'hF; end
        exp = model_write(32'h0, 14, 3'd2, 2'b01, -1);
        axi_write(32'h0, 4'd14, 3'd2, 2'b01, 8'h5A, -1);
        vectors++;
        if (wr_bresp !== exp) begin miscompares++; $display("FAIL fill_bresp: got %b want %b", wr_bresp, exp); end
        addr = {26'h0, 4'($urandom), 2'b00};
        id = 8'($urandom);
        axi_read(addr, 4'd7, 3'd2, 2'b01, id, 1'b1);
        vectors++;
        if (rd_data.size() != 8) begin miscompares++; $display("FAIL stall_beats: got %0d want 8", rd_data.size()); end
        vectors++;
        if (rd_stall_bad != 0) begin miscompares++; $display("FAIL stall_stable: got %0d changes want 0", rd_stall_bad); end
        for (int i = 0; i < rd_data.size(); i++) begin
            vectors++;
            if (rd_data[i] !== model_beat(addr, 3'd2, 2'b01, i) || rd_last[i] !== (i == 7) ||
                rd_id[i] !== id || rd_resp[i] !== 2'b00) begin
                miscompares++;
                $display("FAIL stall_beat[%0d]: got %h/%b/%h/%b want %h/%b/%h/00", i, rd_data[i], rd_last[i], rd_id[i],
                         rd_resp[i], model_beat(addr, 3'd2, 2'b01, i), i == 7, id);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst, exp;
        logic [7:0]  id;
        for (int t = 0; t < 30; t++) begin
            addr  = ($urandom_range(0, 9) == 0) ? {26'($urandom), 6'($urandom)} : {26'h0, 4'($urandom), 2'b00};
            size  = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd2;
            burst = 2'($urandom_range(0, 2));
            len   = 4'($urandom);
            id    = 8'($urandom);
            for (int i = 0; i < 16; i++) begin wr_data[i] = 32'($urandom); wr_strb[i] = 4'($urandom); end
            exp = model_write(addr, int'(len), size, burst, -1);
            axi_write(addr, len, size, burst, id, -1);
            vectors++;
            if (wr_bresp !== exp || wr_bid !== id) begin
                miscompares++;
                $display("FAIL rand_b[%0d]: got %b/%h want %b/%h", t, wr_bresp, wr_bid, exp, id);
            end
            addr  = ($urandom_range(0, 9) == 0) ? {26'($urandom), 6'($urandom)} : {26'h0, 4'($urandom), 2'b00};
            size  = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd2;
            burst = 2'($urandom_range(0, 2));
            len   = 4'($urandom);
            id    = 8'($urandom);
            axi_read(addr, len, size, burst, id, 1'($urandom));
            vectors++;
            if (rd_data.size() != int'(len) + 1 || rd_stall_bad != 0) begin
                miscompares++;
                $display("FAIL rand_r_beats[%0d]: got %0d/%0d want %0d/0", t, rd_data.size(), rd_stall_bad, len + 1);
            end
            for (int i = 0; i < rd_data.size(); i++) begin
                vectors++;
                if (rd_data[i] !== model_beat(addr, size, burst, i) || rd_resp[i] !== model_status(addr, size) ||
                    rd_last[i] !== (i == int'(len)) || rd_id[i] !== id) begin
                    miscompares++;
                    $display("FAIL rand_r[%0d][%0d]: got %h/%b/%b/%h want %h/%b/%b/%h", t, i, rd_data[i], rd_resp[i],
                             rd_last[i], rd_id[i], model_beat(addr, size, burst, i), model_status(addr, size),
                             i == int'(len), id);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        logic bvalid_seen, awready_in_reset;
        bvalid_seen = 1'b0; awready_in_reset = 1'b0;
        @(posedge clk); #1;
        bus.AWID = 8'h77; bus.AWADDR = 32'h10; bus.AWLEN = 4'd3; bus.AWSIZE = 3'd2;
        bus.AWBURST = 2'b01; bus.AWVALID = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.AWREADY && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.WDATA = 32'($urandom) | 32'h1; bus.WSTRB = 4'hF; bus.WLAST = 1'b0; bus.WVALID = 1'b1;
            @(negedge clk);
            if (i == 2) break;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) model_regs[i] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (bus.BVALID) bvalid_seen = 1'b1;
            if (bus.AWREADY) awready_in_reset = 1'b1;
            @(negedge clk);
        end
        init_bus();
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (bus.AWREADY !== 1'b1 || awready_in_reset) begin
            miscompares++;
            $display("FAIL midreset_awready: got after=%b during=%b want 1 0", bus.AWREADY, awready_in_reset);
        end
        repeat (5) begin
            if (bus.BVALID) bvalid_seen = 1'b1;
            @(posedge clk); #1;
        end
        vectors++;
        if (bvalid_seen !== 1'b0) begin miscompares++; $display("FAIL midreset_bvalid: got 1 want 0"); end
        axi_read(32'h0, 4'd15, 3'd2, 2'b01, 8'h99, 1'b0);
        for (int i = 0; i < rd_data.size(); i++) begin
            vectors++;
            if (rd_data[i] !== model_beat(32'h0, 3'd2, 2'b01, i)) begin
                miscompares++;
                $display("FAIL midreset_regs[%0d]: got %h want %h", i, rd_data[i], model_beat(32'h0, 3'd2, 2'b01, i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write_read();
        test_incr_wrap();
        test_errors();
        test_strobe();
        test_fixed_and_wlast();
        test_read_stall();
        test_random();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
